// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit add processed DIGIT bits per clock with a registered carry.
// Optional subtract mode and `sub` port are enabled by defining DS_ADD_SUB_EN.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DS_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One DIGIT-wide carry chain; the extra bit is the digit carry-out.
    logic [DIGIT:0]   dsum;
    logic             msb_carry_in;
    logic [WIDTH-1:0] acc_next;

    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    assign msb_carry_in = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DS_ADD_SUB_EN
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_next;
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Results are published only here so they stay stable through RUN.
                    sum_d   = acc_next;
                    cout_d  = dsum[DIGIT];
                    ovf_d   = msb_carry_in ^ dsum[DIGIT];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: a DIGIT=1 and a DIGIT=4 instance, WIDTH=8.
// Subtract vectors run only when DS_ADD_SUB_EN is defined.
module tb_digit_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] a_r = 8'h00;
    logic [7:0] b_r = 8'h00;
    logic       cin_r = 1'b0;
    logic       sub_r = 1'b0;

    logic       start8, start4;
    logic       busy8, done8, cout8, ovf8;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum8, sum4;
    logic       busy_m, done_m, cout_m, ovf_m;
    logic [7:0] sum_m;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign start8 = start_r & ~sel;
    assign start4 = start_r & sel;
    assign busy_m = sel ? busy4 : busy8;
    assign done_m = sel ? done4 : done8;
    assign sum_m  = sel ? sum4  : sum8;
    assign cout_m = sel ? cout4 : cout8;
    assign ovf_m  = sel ? ovf4  : ovf8;

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start8), .a(a_r), .b(b_r), .cin(cin_r),
`ifdef DS_ADD_SUB_EN
        .sub(sub_r),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start4), .a(a_r), .b(b_r), .cin(cin_r),
`ifdef DS_ADD_SUB_EN
        .sub(sub_r),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    typedef struct {
        string      name;
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to a bounded number of edges for done; returns edges waited (or limit+1 on timeout).
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy_m) busy_cnt++;
            tick();
            cyc = i;
            if (done_m) return;
        end
        cyc = 41;
    endtask

    task automatic run_op(input vec_t v);
        int cyc, bc;
        sel = v.sel;
        tick();
        a_r = v.a; b_r = v.b; cin_r = v.cin; sub_r = v.sub; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        check({v.name, " busy_after_start"}, {31'd0, busy_m}, 32'd1);
        wait_done(cyc, bc);
        check({v.name, " latency"}, cyc, v.lat);
        check({v.name, " busy_cycles"}, bc, v.lat);
        check({v.name, " sum"}, {24'd0, sum_m}, {24'd0, v.sum});
        check({v.name, " cout"}, {31'd0, cout_m}, {31'd0, v.cout});
        check({v.name, " ovf"}, {31'd0, ovf_m}, {31'd0, v.ovf});
        tick();
        check({v.name, " done_pulse_width"}, {31'd0, done_m}, 32'd0);
        sub_r = 1'b0;
    endtask

    initial begin
        int cyc, bc, dones;

        //          name          sel   a      b      cin   sub   sum    cout  ovf   lat
        vecs.push_back('{"zero",    1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8});
        vecs.push_back('{"ff_p_01", 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8});
        vecs.push_back('{"7f_p_01", 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8});
        vecs.push_back('{"12_34_c", 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 8});
        vecs.push_back('{"80_p_80", 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8});
        vecs.push_back('{"55_aa_c", 1'b0, 8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8});
        vecs.push_back('{"d4_a5_5b",1'b1, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2});
        vecs.push_back('{"d4_7f_01",1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 2});
`ifdef DS_ADD_SUB_EN
        vecs.push_back('{"sub_05_07",1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8});
        vecs.push_back('{"sub_80_01",1'b0, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 8});
        vecs.push_back('{"d4_sub_10_10",1'b1, 8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2});
`endif
        vecs.push_back('{"c8_p_9c", 1'b0, 8'hC8, 8'h9C, 1'b0, 1'b0, 8'h64, 1'b1, 1'b1, 8});

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst busy8", {31'd0, busy8}, 32'd0);
        check("rst done8", {31'd0, done8}, 32'd0);
        check("rst sum8",  {24'd0, sum8},  32'd0);
        check("rst cout_ovf8", {30'd0, cout8, ovf8}, 32'd0);
        check("rst busy_done4", {30'd0, busy4, done4}, 32'd0);
        check("rst sum4",  {24'd0, sum4},  32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Start while busy is ignored; outputs hold mid-run
        sel = 1'b0;
        a_r = 8'h12; b_r = 8'h34; cin_r = 1'b1; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick(); tick();
        check("ign sum_held", {24'd0, sum8}, 32'h64);
        a_r = 8'hFF; b_r = 8'hFF; cin_r = 1'b0; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        check("ign still_busy", {31'd0, busy8}, 32'd1);
        wait_done(cyc, bc);
        check("ign latency", cyc + 3, 8);
        check("ign sum", {24'd0, sum8}, 32'h47);
        check("ign cout", {31'd0, cout8}, 32'd0);
        tick();
        check("ign idle", {30'd0, busy8, done8}, 32'd0);

        // Reset during RUN aborts without a done pulse
        a_r = 8'h55; b_r = 8'hAA; cin_r = 1'b0; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {31'd0, busy8}, 32'd0);
        check("abort done", {31'd0, done8}, 32'd0);
        check("abort sum",  {24'd0, sum8},  32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dones++;
        end
        check("abort no_done", dones, 0);
        run_op('{"after_abort", 1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 8});

        // Back-to-back: start held high through DONE
        sel = 1'b0;
        a_r = 8'h01; b_r = 8'h02; cin_r = 1'b0; start_r = 1'b1;
        tick();
        wait_done(cyc, bc);
        check("b2b first_latency", cyc, 8);
        check("b2b first_sum", {24'd0, sum8}, 32'h03);
        a_r = 8'h03; b_r = 8'h04;
        tick();
        start_r = 1'b0;
        check("b2b accepted_in_done", {30'd0, busy8, done8}, 32'd2);
        wait_done(cyc, bc);
        check("b2b second_latency", cyc, 8);
        check("b2b second_sum", {24'd0, sum8}, 32'h07);
        tick();
        check("b2b idle", {30'd0, busy8, done8}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
